// File: rtl/imm_encoder.sv
// RV32 immediate encoder: places an immediate into the I/S/B/J/U bit positions of a
// caller-supplied instruction template, flagging values the format cannot represent.
module imm_encoder #(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_immsrc,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_tmpl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count,
  input  logic                err_clr
);

  // Format codes; must match the IMMSRC_* values used by the instruction injectors.
  localparam logic [2:0] IMMSRC_ITYPE = 3'd0;
  localparam logic [2:0] IMMSRC_STYPE = 3'd1;
  localparam logic [2:0] IMMSRC_BTYPE = 3'd2;
  localparam logic [2:0] IMMSRC_JTYPE = 3'd3;
  localparam logic [2:0] IMMSRC_UTYPE = 3'd4;

  logic                s1_valid_q;
  logic [2:0]          s1_immsrc_q;
  logic [31:0]         s1_imm_q;
  logic [31:0]         s1_tmpl_q;
  logic                s1_err_q;
  logic                s2_valid_q;
  logic [31:0]         s2_instr_q;
  logic                s2_err_q;
  logic [ERRCNT_W-1:0] err_count_q;

  logic        s1_load;
  logic        s2_load;
  logic        range_err_d;
  logic [31:0] enc_instr_d;
  logic        hi11_uniform;
  logic        hi12_uniform;
  logic        hi20_uniform;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // An immediate fits when every bit above the field's sign bit copies that sign bit.
  assign hi11_uniform = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign hi12_uniform = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign hi20_uniform = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    range_err_d = 1'b1;
    case (in_immsrc)
      IMMSRC_ITYPE, IMMSRC_STYPE: range_err_d = !hi11_uniform;
      IMMSRC_BTYPE:               range_err_d = in_imm[0] || !hi12_uniform;
      IMMSRC_JTYPE:               range_err_d = in_imm[0] || !hi20_uniform;
      IMMSRC_UTYPE:               range_err_d = |in_imm[11:0];
      default:                    range_err_d = 1'b1;
    endcase
  end

  always_comb begin
    enc_instr_d = s1_tmpl_q;
    case (s1_immsrc_q)
      IMMSRC_ITYPE: enc_instr_d[31:20] = s1_imm_q[11:0];
      IMMSRC_STYPE: begin
        enc_instr_d[31:25] = s1_imm_q[11:5];
        enc_instr_d[11:7]  = s1_imm_q[4:0];
      end
      IMMSRC_BTYPE: begin
        enc_instr_d[31]    = s1_imm_q[12];
        enc_instr_d[30:25] = s1_imm_q[10:5];
        enc_instr_d[11:8]  = s1_imm_q[4:1];
        enc_instr_d[7]     = s1_imm_q[11];
      end
      IMMSRC_JTYPE: begin
        enc_instr_d[31]    = s1_imm_q[20];
        enc_instr_d[30:21] = s1_imm_q[10:1];
        enc_instr_d[20]    = s1_imm_q[11];
        enc_instr_d[19:12] = s1_imm_q[19:12];
      end
      IMMSRC_UTYPE: enc_instr_d[31:12] = s1_imm_q[31:12];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_immsrc_q <= '0;
      s1_imm_q    <= '0;
      s1_tmpl_q   <= '0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_immsrc_q <= in_immsrc;
          s1_imm_q    <= in_imm;
          s1_tmpl_q   <= in_tmpl;
          s1_err_q    <= range_err_d;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_instr_q <= enc_instr_d;
          s2_err_q   <= s1_err_q;
        end
      end
      // Clear wins over a simultaneous increment.
      if (err_clr) begin
        err_count_q <= '0;
      end else if (s2_valid_q && out_ready && s2_err_q && !(&err_count_q)) begin
        err_count_q <= err_count_q + ERRCNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, stall/reset sequences, and a random
// stream checked by decoding the output word back against the immediate.
module tb_imm_encoder;

  localparam int CW = 4;
  localparam logic [2:0] FI = 3'd0, FS = 3'd1, FB = 3'd2, FJ = 3'd3, FU = 3'd4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_immsrc = '0;
  logic [31:0]   in_imm = '0;
  logic [31:0]   in_tmpl = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_count;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  imm_encoder #(.ERRCNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_immsrc(in_immsrc), .in_imm(in_imm), .in_tmpl(in_tmpl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .err_count(err_count), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] w);
    case (src)
      FI: return {{20{w[31]}}, w[31:20]};
      FS: return {{20{w[31]}}, w[31:25], w[11:7]};
      FB: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FJ: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      FU: return {w[31:12], 12'h000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] src);
    case (src)
      FI:      return 32'hFFF0_0000;
      FS, FB:  return 32'hFE00_0F80;
      FJ, FU:  return 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  // Value a decoder recovers: the immediate reduced modulo the field's range.
  function automatic logic [31:0] exp_value(input logic [2:0] src, input logic [31:0] imm);
    int s;
    s = int'(imm);
    case (src)
      FI, FS:  return 32'((s <<< 20) >>> 20);
      FB:      return 32'(((s & ~1) <<< 19) >>> 19);
      FJ:      return 32'(((s & ~1) <<< 11) >>> 11);
      FU:      return imm & 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_error(input logic [2:0] src, input logic [31:0] imm);
    longint s;
    s = longint'(int'(imm));
    case (src)
      FI, FS:  return (s < -2048) || (s > 2047);
      FB:      return imm[0] || (s < -4096) || (s > 4095);
      FJ:      return imm[0] || (s < -1048576) || (s > 1048575);
      FU:      return (imm % 32'd4096) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] tmpl;
  } req_t;

  req_t          sb_q[$];
  req_t          sb_r;
  logic [CW-1:0] exp_cnt = '0;
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_instr = '0;
  logic          prev_err = 1'b0;
  logic          r_err;

  always @(negedge clk) begin
    if (!resetn) begin
      sb_q.delete();
      exp_cnt = '0;
      prev_stall = 1'b0;
    end else begin
      check("err_count", 32'(err_count), 32'(exp_cnt));
      if (prev_stall) begin
        check("stall_instr", out_instr, prev_instr);
        check("stall_err", 32'(out_err), 32'(prev_err));
      end
      r_err = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'h0);
        end else begin
          sb_r = sb_q.pop_front();
          r_err = exp_error(sb_r.src, sb_r.imm);
          if (sb_r.src > FU) begin
            check("passthru_word", out_instr, sb_r.tmpl);
          end else begin
            check("decoded_imm", decode(sb_r.src, out_instr), exp_value(sb_r.src, sb_r.imm));
            check("tmpl_bits", out_instr & ~field_mask(sb_r.src), sb_r.tmpl & ~field_mask(sb_r.src));
          end
          check("out_err", 32'(out_err), 32'(r_err));
        end
      end
      if (in_valid && in_ready) sb_q.push_back('{in_immsrc, in_imm, in_tmpl});
      if (err_clr) exp_cnt = '0;
      else if (out_valid && out_ready && r_err && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] tmpl;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];
  req_t stall_reqs[4];
  logic [31:0] corner[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] tmpl);
    in_immsrc = src;
    in_imm    = imm;
    in_tmpl   = tmpl;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && (sb_q.size() != 0 || out_valid); k++) tick();
    check("drain_empty", 32'(sb_q.size()), 32'h0);
  endtask

  int idx;
  int accepted;
  int cycles;
  int kind;

  initial begin
    vecs[0]  = '{FI, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{FB, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0};
    vecs[2]  = '{FB, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1};
    vecs[3]  = '{FU, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0};
    vecs[4]  = '{FU, 32'h1234_5001, 32'h0000_0537, 32'h1234_5537, 1'b1};
    vecs[5]  = '{FJ, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1};
    vecs[6]  = '{FS, 32'hFFFF_F800, 32'h0000_2023, 32'h8000_2023, 1'b0};
    vecs[7]  = '{FI, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    vecs[8]  = '{3'd5, 32'h0000_0123, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{FJ, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0};
    vecs[10] = '{FS, 32'h0000_07FF, 32'h0000_0000, 32'h7E00_0F80, 1'b0};
    vecs[11] = '{FI, 32'hFFFF_F7FF, 32'h0000_0013, 32'h7FF0_0013, 1'b1};

    stall_reqs[0] = '{FI, 32'h0000_07FF, 32'h0000_0093};
    stall_reqs[1] = '{FB, 32'h0000_0003, 32'h0000_0063};
    stall_reqs[2] = '{FU, 32'hABCD_E000, 32'h0000_00B7};
    stall_reqs[3] = '{FS, 32'h0000_1000, 32'h0000_2023};

    corner = '{32'h7FF, 32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFE, 32'h1000,
               32'hFFFF_F000, 32'hFFFF_EFFE, 32'hF_FFFE, 32'h10_0000, 32'hFFF0_0000, 32'h1234_5000};

    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err", 32'(out_err), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);

    // Directed table, one request at a time, with latency check
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].src, vecs[i].imm, vecs[i].tmpl);
      check("vec_in_ready", 32'(in_ready), 32'h1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("vec_lat1_valid", 32'(out_valid), 32'h0);
      tick();
      check("vec_lat2_valid", 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      tick();
    end
    check("table_err_count", 32'(err_count), 32'd6);

    // err_count increment on handshake, and clear beating a same-cycle increment
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_count", 32'(err_count), 32'h0);
    out_ready = 1'b0;
    drive(FJ, 32'h0000_0003, 32'h0000_006F);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("j_odd_err", 32'(out_err), 32'h1);
    check("count_before_hs", 32'(err_count), 32'h0);
    out_ready = 1'b1;
    tick();
    check("count_after_hs", 32'(err_count), 32'h1);
    out_ready = 1'b0;
    drive(FJ, 32'h0000_0005, 32'h0000_006F);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_priority", 32'(err_count), 32'h0);
    drain();

    // Stall: only two requests fit while the output is blocked
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(stall_reqs[idx].src, stall_reqs[idx].imm, stall_reqs[idx].tmpl);
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    check("stall_accepts", 32'(idx), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      drive(stall_reqs[idx].src, stall_reqs[idx].imm, stall_reqs[idx].tmpl);
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    check("stall_all_sent", 32'(idx), 32'd4);
    drain();
    check("stall_err_count", 32'(err_count), 32'd2);

    // Reset with two requests in flight
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      drive(FU, 32'h0000_0001, 32'h0);
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("inflight_count", 32'(idx), 32'd2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    out_ready = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_err_count", 32'(err_count), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("midrst_no_output", 32'(out_valid), 32'h0);

    // Random stream against the decode model
    accepted = 0;
    cycles = 0;
    while (accepted < 10000 && cycles < 40000) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      err_clr   = ($urandom % 50) == 0;
      kind = $urandom % 10;
      in_immsrc = (kind < 9) ? 3'(kind % 5) : 3'(5 + $urandom % 3);
      kind = $urandom % 5;
      case (kind)
        0: in_imm = $urandom;
        1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: in_imm = 32'($signed($urandom) >>> ($urandom % 32));
        3: in_imm = corner[$urandom % 12];
        default: in_imm = $urandom << 12;
      endcase
      in_tmpl = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      tick();
      cycles++;
    end
    err_clr = 1'b0;
    check("random_accepted", 32'(accepted), 32'd10000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
